// File: rtl/rst_seq_pkg.sv
// Shared state encoding and reset-cause codes for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_PLL    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SW     = 2'd2;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous input, with a chosen value
// forced into every stage while reset is asserted.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds every downstream domain in reset, waits a settle
// period, then releases the outputs one by one from bit 0 upward.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int CNT_WIDTH   = 24,
  parameter int GAP_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_in_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 2);

  state_t               state;
  logic [CNT_WIDTH-1:0] settle;
  logic [GAP_W-1:0]     gap;
  logic [IDX_W-1:0]     idx;
  logic                 btn_sync;
  logic                 rst_event;

  sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_btn_sync (
    .clk(clk),
    .rst(rst),
    .d  (rst_in_n),
    .q  (btn_sync)
  );

  assign rst_event = !btn_sync || sw_rst_req;

  // Outputs are released by shifting a zero in from the bottom, which keeps
  // rst_out a contiguous run of ones anchored at the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      settle    <= '0;
      gap       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_PLL;
    end else if (rst_event) begin
      state     <= HOLD;
      settle    <= '0;
      gap       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= !btn_sync ? CAUSE_BUTTON : CAUSE_SW;
    end else begin
      case (state)
        HOLD: begin
          if (settle == '1) begin
            rst_out <= rst_out << 1;
            if (NUM_OUT == 1) begin
              state    <= RUN;
              rst_done <= 1'b1;
            end else begin
              state <= STAGE;
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        STAGE: begin
          if (gap == GAP_LAST) begin
            gap     <= '0;
            rst_out <= rst_out << 1;
            idx     <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state    <= RUN;
              rst_done <= 1'b1;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        RUN: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
